// File: rtl/fact_pkg.sv
// Shared definitions for the iterative factorial engine.
package fact_pkg;

  localparam int N_W_DEF = 4;
  localparam int X_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } fact_state_e;

endpackage : fact_pkg

// File: rtl/seq_factorial.sv
// Iterative n! engine: one multiply per clock, descending from n to 2,
// with a start/done handshake and a sticky overflow flag per operation.
module seq_factorial
  import fact_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int X_W = X_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x,
  output logic           ovf
);

  localparam int P_W = X_W + N_W;

  fact_state_e    state_q, state_d;
  logic [X_W-1:0] acc_q, acc_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic           ovf_int_q, ovf_int_d;
  logic [X_W-1:0] x_q, x_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic [P_W-1:0] prod;
  logic           more;

  // Full-width product so bits lost by truncation can be flagged.
  always_comb begin
    prod = {{N_W{1'b0}}, acc_q} * {{X_W{1'b0}}, cnt_q};
    more = (cnt_q > N_W'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave IDLE on start, return once the count is exhausted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (!more) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state_q == CALC);
  end

  // Datapath next values: load on accept, multiply while cnt>1, publish at end.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_int_d = ovf_int_q;
    x_d       = x_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d     = X_W'(1);
          cnt_d     = n;
          ovf_int_d = 1'b0;
        end
      end
      CALC: begin
        if (more) begin
          acc_d = prod[X_W-1:0];
          cnt_d = cnt_q - N_W'(1);
          if (|prod[P_W-1:X_W]) ovf_int_d = 1'b1;
        end else begin
          x_d    = acc_q;
          ovf_d  = ovf_int_q;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= X_W'(1);
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      x_q       <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      x_q       <= x_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;
  assign x    = x_q;
  assign ovf  = ovf_q;

endmodule : seq_factorial

// File: tb/tb_seq_factorial.sv
// Directed bench for seq_factorial with hand-computed expected values.
module tb_seq_factorial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  n = '0;
  logic        busy, done, ovf;
  logic [31:0] x;

  int checks = 0;
  int failures = 0;

  seq_factorial #(.N_W(4), .X_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .busy(busy), .done(done), .x(x), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present start for one edge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [3:0] nv);
    start = 1'b1;
    n     = nv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] nv, input logic [31:0] ex,
                     input logic eo, input int elat);
    int c;
    start_op(nv);
    wait_done(c);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_x"}, 64'(x), 64'(ex));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    chk({tag, "_lat"}, 64'(c), 64'(elat));
    chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int c;
    // Reset held two cycles.
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    // Start during reset is ignored.
    start = 1'b1; n = 4'd3;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("rst_start_busy2", 64'(busy), 64'd0);
    chk("rst_start_done", 64'(done), 64'd0);

    // Small operands.
    run("n0", 4'd0, 32'd1, 1'b0, 1);
    @(negedge clk);
    chk("n0_pulse", 64'(done), 64'd0);
    run("n1", 4'd1, 32'd1, 1'b0, 1);
    @(negedge clk);
    run("n2", 4'd2, 32'd2, 1'b0, 2);
    @(negedge clk);
    run("n3", 4'd3, 32'd6, 1'b0, 3);
    @(negedge clk);

    // Largest fitting, then overflow, then flag clears.
    run("n12", 4'd12, 32'h1C8CFC00, 1'b0, 12);
    @(negedge clk);
    run("n13", 4'd13, 32'h7328CC00, 1'b1, 13);
    @(negedge clk);
    chk("n13_hold_x", 64'(x), 64'h7328CC00);
    chk("n13_hold_ovf", 64'(ovf), 64'd1);
    run("n4", 4'd4, 32'd24, 1'b0, 4);

    // Back-to-back: start in the done cycle.
    start_op(4'd2);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_done_lo", 64'(done), 64'd0);
    chk("b2b_x_hold", 64'(x), 64'd24);
    wait_done(c);
    chk("b2b_x", 64'(x), 64'd2);
    chk("b2b_lat", 64'(c), 64'd2);
    @(negedge clk);

    // Start while busy is ignored; x holds during computation.
    start_op(4'd6);
    start = 1'b1; n = 4'd2;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ign_x_hold", 64'(x), 64'd2);
    wait_done(c);
    chk("busy_ign_x", 64'(x), 64'd720);
    chk("busy_ign_lat", 64'(c + 1), 64'd6);
    @(negedge clk);
    chk("busy_ign_idle", 64'(busy), 64'd0);

    // Full-range operand.
    run("n15", 4'd15, 32'h77775800, 1'b1, 15);
    @(negedge clk);

    // Mid-operation reset.
    start_op(4'd10);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_x", 64'(x), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    c = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) c++;
    end
    chk("mid_rst_quiet", 64'(c), 64'd0);
    run("n5", 4'd5, 32'd120, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_factorial
